// File: rtl/nibble_shift_pkg.sv
// Shared definitions for the nibble shift controller slice.
// Contents: FSM state enum and the datapath widths used by
// nibble_shift_ctrl and shift_tick_gen.
package nibble_shift_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned BITCNT_W = 3;
  localparam int unsigned PRESC_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_shift_ctrl_shift_tick_gen.sv
// shift_tick_gen: DIV prescaler that paces the shift-enable pulses.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, clears the prescaler
//   start - preset the prescaler to DIV-1 (asserted during LOAD)
//   run   - count enable (asserted during SHIFT)
//   tick  - high in a run cycle where the prescaler is 0
module shift_tick_gen
  import nibble_shift_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic tick
);

  localparam logic [PRESC_W-1:0] RELOAD = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] presc;

  assign tick = run && (presc == '0);

  // Reload on zero so the counter never wraps below 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (start) begin
      presc <= RELOAD;
    end else if (run) begin
      if (presc == '0) presc <= RELOAD;
      else             presc <= presc - 1'b1;
    end
  end

endmodule

// File: rtl/nibble_shift_ctrl.sv
// nibble_shift_ctrl: sequencer feeding a 4-bit right-shift register.
// Accepts nibbles over valid/ready, then issues one load pulse followed
// by NBITS shift-enable pulses spaced DIV cycles apart, and a done pulse.
// Optional feature macro: NIBBLE_SHIFT_CTRL_PREFETCH_EN adds a one-entry
// prefetch slot so back-to-back nibbles run with period 4*DIV+2.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   in_valid, in_data  - upstream nibble handshake (input side)
//   in_ready           - controller can accept a nibble this cycle
//   load, data         - load pulse and nibble for the shift register
//   ena                - shift pulse for the shift register
//   busy               - high from the load cycle through the done cycle
//   done               - one-cycle pulse after the last shift
module nibble_shift_ctrl
  import nibble_shift_pkg::*;
#(
  parameter int unsigned DIV   = 1,
  parameter int unsigned NBITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [NIBBLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                load,
  output logic                ena,
  output logic [NIBBLE_W-1:0] data,
  output logic                busy,
  output logic                done
);

  state_t              state;
  logic [BITCNT_W-1:0] bitcnt;
  logic [NIBBLE_W-1:0] hold;
  logic                xfer;
  logic                tick;
  logic                tick_start;
  logic                tick_run;
  logic                last_bit;

`ifdef NIBBLE_SHIFT_CTRL_PREFETCH_EN
  logic                next_full;
  logic [NIBBLE_W-1:0] next_data;

  assign in_ready = !reset && ((state == IDLE) || !next_full);
`else
  assign in_ready = !reset && (state == IDLE);
`endif

  assign xfer       = in_valid && in_ready;
  assign tick_start = (state == LOAD);
  assign tick_run   = (state == SHIFT);
  assign last_bit   = tick && (bitcnt == BITCNT_W'(NBITS - 1));
  assign ena        = tick;
  assign data       = hold;

  shift_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .start (tick_start),
    .run   (tick_run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      hold   <= '0;
      load   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef NIBBLE_SHIFT_CTRL_PREFETCH_EN
      next_full <= 1'b0;
      next_data <= '0;
`endif
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            hold  <= in_data;
            state <= LOAD;
            load  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          bitcnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            bitcnt <= bitcnt + 1'b1;
            if (last_bit) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
`ifdef NIBBLE_SHIFT_CTRL_PREFETCH_EN
          // A nibble accepted during DONE with the slot empty bypasses the
          // slot and loads straight away, keeping the back-to-back period.
          if (next_full) begin
            hold      <= next_data;
            next_full <= 1'b0;
            state     <= LOAD;
            load      <= 1'b1;
          end else if (xfer) begin
            hold  <= in_data;
            state <= LOAD;
            load  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
`ifdef NIBBLE_SHIFT_CTRL_PREFETCH_EN
      if (xfer && ((state == LOAD) || (state == SHIFT))) begin
        next_data <= in_data;
        next_full <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_nibble_shift_ctrl.sv
// Testbench for nibble_shift_ctrl: two instances (DIV=1 and DIV=3) share
// one stimulus stream; each is checked every cycle against a timeline
// model built from load-cycle offsets, plus a modelled shift register.
`timescale 1ns/1ps
module tb_nibble_shift_ctrl;

`ifdef NIBBLE_SHIFT_CTRL_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data  = 4'h0;

  logic       rdy [2];
  logic       ld  [2];
  logic       en  [2];
  logic       bsy [2];
  logic       dn  [2];
  logic [3:0] dat [2];

  nibble_shift_ctrl #(.DIV(1), .NBITS(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .load(ld[0]), .ena(en[0]), .data(dat[0]),
    .busy(bsy[0]), .done(dn[0])
  );

  nibble_shift_ctrl #(.DIV(3), .NBITS(4)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .load(ld[1]), .ena(en[1]), .data(dat[1]),
    .busy(bsy[1]), .done(dn[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state per instance: load cycle of the current nibble, the nibble
  // itself, the prefetch slot, and a shift register fed by the DUT outputs.
  int         job_l    [2];
  logic [3:0] exp_data [2];
  logic       pend_v   [2];
  logic [3:0] pend_d   [2];
  logic       acc      [2];
  logic [3:0] sr       [2];
  logic [3:0] emit     [2];

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic eval(input int i);
    int d, off, k;
    bit act, e_load, e_ena, e_done, e_rdy;
    string p;
    d      = div_of(i);
    off    = cyc - job_l[i];
    act    = (job_l[i] >= 0) && (off >= 0) && (off <= 1 + 4 * d);
    e_load = act && (off == 0);
    e_ena  = act && (off > 0) && (off <= 4 * d) && (off % d == 0);
    e_done = act && (off == 1 + 4 * d);
    e_rdy  = !reset && (!act || (PF && !pend_v[i]));
    p = $sformatf("dut%0d c%0d", i, cyc);

    check({p, " in_ready"}, 4'(rdy[i]), 4'(e_rdy));
    check({p, " load"},     4'(ld[i]),  4'(e_load));
    check({p, " ena"},      4'(en[i]),  4'(e_ena));
    check({p, " done"},     4'(dn[i]),  4'(e_done));
    check({p, " busy"},     4'(bsy[i]), 4'(act));
    check({p, " data"},     dat[i],     exp_data[i]);
    if (e_ena && en[i]) begin
      k = off / d - 1;
      check({p, " serial_bit"}, 4'(sr[i][0]), 4'(exp_data[i][k]));
    end

    if (ld[i]) sr[i] = dat[i];
    else if (en[i]) begin
      emit[i] = {sr[i][0], emit[i][3:1]};
      sr[i]   = sr[i] >> 1;
    end

    acc[i] = 1'b0;
    if (reset) begin
      job_l[i]    = -1000;
      pend_v[i]   = 1'b0;
      exp_data[i] = 4'h0;
    end else begin
      if (in_valid && e_rdy) begin
        acc[i] = 1'b1;
        if (!act || e_done) begin
          job_l[i]    = cyc + 1;
          exp_data[i] = in_data;
        end else begin
          pend_v[i] = 1'b1;
          pend_d[i] = in_data;
        end
      end else if (e_done && pend_v[i]) begin
        job_l[i]    = cyc + 1;
        exp_data[i] = pend_d[i];
        pend_v[i]   = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] d);
    @(posedge clk);
    #1;
    cyc++;
    reset    = r;
    in_valid = v;
    in_data  = d;
    #1;
    for (int i = 0; i < 2; i++) eval(i);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin
      job_l[i] = -1000; exp_data[i] = 4'h0; pend_v[i] = 1'b0;
      pend_d[i] = 4'h0; acc[i] = 1'b0; sr[i] = 4'h0; emit[i] = 4'h0;
    end

    // Reset, then quiet idle.
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    idle(10);

    // Single nibble 4'hB: serial stream 1,1,0,1 leaves the register empty.
    for (int i = 0; i < 2; i++) emit[i] = 4'h0;
    step(1'b0, 1'b1, 4'hB);
    idle(16);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d emitted_B", i), emit[i], 4'hB);
      check($sformatf("dut%0d sr_empty", i), sr[i], 4'h0);
    end

    // Nibble 4'h6 (paced by DIV in each instance).
    step(1'b0, 1'b1, 4'h6);
    idle(16);

    // Reset in cycle 3 of a sequence, then a fresh nibble 4'h9.
    step(1'b0, 1'b1, 4'hA);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h9);
    idle(16);

    // Continuous valid with 1,2,3 (advanced on the DIV=1 instance's accepts).
    k = 0;
    for (int j = 0; j < 34; j++) begin
      step(1'b0, (k < 3), 4'(k + 1));
      if (acc[0]) k++;
    end
    check("dut0 continuous_accepts", 4'(k), 4'd3);
    idle(16);

    // Randomised traffic with occasional reset.
    for (int j = 0; j < 2000; j++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
           4'($urandom_range(0, 15)));
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
